// File: rtl/frame_loader_if.sv
// frame_loader_if: HPS beat stream plus led_band_controller write port of frame_loader
// s_data/s_valid/s_sof/s_ready: narrow input beat stream with start-of-frame marker
// w_addr_input/w_data/write: controller write port; new_frame/frame_error/busy: status
// master: the loader side; slave: the environment side (feeder and controller)
interface frame_loader_if #(
  parameter int IN_DATA_WIDTH = 32,
  parameter int W_DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH    = 10
);
  logic [IN_DATA_WIDTH-1:0] s_data;
  logic                     s_valid;
  logic                     s_sof;
  logic                     s_ready;
  logic [ADDR_WIDTH-1:0]    w_addr_input;
  logic [W_DATA_WIDTH-1:0]  w_data;
  logic                     write;
  logic                     new_frame;
  logic                     frame_error;
  logic                     busy;
  modport master (
    input  s_data, s_valid, s_sof,
    output s_ready, w_addr_input, w_data, write, new_frame, frame_error, busy
  );
  modport slave (
    output s_data, s_valid, s_sof,
    input  s_ready, w_addr_input, w_data, write, new_frame, frame_error, busy
  );
endinterface

// File: rtl/frame_loader.sv
// frame_loader: packs HPS stream beats into controller words, writes a half-buffer, pulses new_frame
// clk, rst: clock and asynchronous active-high reset
// bus (frame_loader_if.master): s_* beat stream in, s_ready out, write port and status out
module frame_loader #(
  parameter int IN_DATA_WIDTH = 32,
  parameter int W_DATA_WIDTH  = 128,
  parameter int BIT_PER_COLOR = 8,
  parameter int NB_LED_COLUMN = 32,
  parameter int NB_ANGLES     = 128
) (
  input logic            clk,
  input logic            rst,
  frame_loader_if.master bus
);
  localparam int BEATS_PER_WORD = W_DATA_WIDTH / IN_DATA_WIDTH;
  localparam int FRAME_WORDS    = 3 * BIT_PER_COLOR * NB_LED_COLUMN * NB_ANGLES / W_DATA_WIDTH;
  localparam int W_ADDR_WIDTH   = $clog2(2 * FRAME_WORDS);
  localparam int AW             = W_ADDR_WIDTH - 1;
  localparam int BW             = BEATS_PER_WORD > 1 ? $clog2(BEATS_PER_WORD) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  state_t                  state;
  logic [BW-1:0]           beat;
  logic [AW-1:0]           wcnt;
  logic [W_DATA_WIDTH-1:0] pack;
  logic [W_DATA_WIDTH-1:0] packed_word;
  logic [BW-1:0]           lane;
  logic                    accept;
  assign accept = bus.s_valid & bus.s_ready;
  // a start-of-frame beat always lands in lane 0, whatever the beat counter says
  always_comb begin
    lane = (state == LOAD && !bus.s_sof) ? beat : '0;
    packed_word = pack;
    packed_word[lane*IN_DATA_WIDTH +: IN_DATA_WIDTH] = bus.s_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      beat             <= '0;
      wcnt             <= '0;
      pack             <= '0;
      bus.s_ready      <= 1'b0;
      bus.w_addr_input <= '0;
      bus.w_data       <= '0;
      bus.write        <= 1'b0;
      bus.new_frame    <= 1'b0;
      bus.frame_error  <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.write       <= 1'b0;
      bus.new_frame   <= 1'b0;
      bus.frame_error <= 1'b0;
      bus.s_ready     <= 1'b1;
      case (state)
        IDLE: if (accept && bus.s_sof) begin
          pack     <= packed_word;
          beat     <= BW'(1);
          wcnt     <= '0;
          state    <= LOAD;
          bus.busy <= 1'b1;
        end
        LOAD: if (accept) begin
          pack <= packed_word;
          // abort wins over completing the current word
          if (bus.s_sof) begin
            beat            <= BW'(1);
            wcnt            <= '0;
            bus.frame_error <= 1'b1;
          end else if (beat == BW'(BEATS_PER_WORD - 1)) begin
            bus.write        <= 1'b1;
            bus.w_data       <= packed_word;
            bus.w_addr_input <= wcnt;
            wcnt             <= wcnt + 1'b1;
            beat             <= '0;
            if (wcnt == AW'(FRAME_WORDS - 1)) begin
              state       <= COMMIT;
              bus.s_ready <= 1'b0;
            end
          end else begin
            beat <= beat + 1'b1;
          end
        end
        COMMIT: begin
          // s_ready stays low one more cycle so nothing is taken while new_frame is high
          bus.new_frame <= 1'b1;
          bus.s_ready   <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: randomized and directed stimulus checked against a queue-based frame model
module tb_frame_loader;
  localparam int IW = 32, WW = 128, AW = 10, BPW = 4, FW = 768, LOGN = 8192;
  logic clk = 1'b0;
  logic rst = 1'b1;
  frame_loader_if #(.IN_DATA_WIDTH(IW), .W_DATA_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();
  frame_loader #(.IN_DATA_WIDTH(IW), .W_DATA_WIDTH(WW), .BIT_PER_COLOR(8), .NB_LED_COLUMN(32), .NB_ANGLES(128))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  logic           e_ready, e_write, e_nf, e_err, e_busy, acc;
  logic [AW-1:0]  e_addr;
  logic [WW-1:0]  e_data;
  bit             loading;
  int             word, tail;
  logic [IW-1:0]  bq[$];
  int             n_wr = 0, n_nf = 0, n_fe = 0;
  logic [WW-1:0]  wr_seq[LOGN];
  logic [AW-1:0]  wr_adr[LOGN];
  always @(negedge clk) begin
    if (rst) begin
      {e_ready, e_write, e_nf, e_err, e_busy} = '0;
      e_addr = '0;
      e_data = '0;
      loading = 0;
      word = 0;
      tail = 0;
      bq.delete();
    end
    chk("s_ready", WW'(bus.s_ready), WW'(e_ready));
    chk("write", WW'(bus.write), WW'(e_write));
    chk("new_frame", WW'(bus.new_frame), WW'(e_nf));
    chk("frame_error", WW'(bus.frame_error), WW'(e_err));
    chk("busy", WW'(bus.busy), WW'(e_busy));
    chk("w_addr_input", WW'(bus.w_addr_input), WW'(e_addr));
    chk("w_data", bus.w_data, e_data);
    if (!rst) begin
      if (bus.write && n_wr < LOGN) begin
        wr_seq[n_wr] = bus.w_data;
        wr_adr[n_wr] = bus.w_addr_input;
        n_wr++;
      end
      if (bus.new_frame) n_nf++;
      if (bus.frame_error) n_fe++;
      acc = bus.s_valid && e_ready;
      e_write = 0;
      e_nf = 0;
      e_err = 0;
      if (tail == 2) begin
        e_nf = 1;
        e_ready = 0;
        tail = 1;
      end else if (tail == 1) begin
        e_ready = 1;
        tail = 0;
      end else begin
        e_ready = 1;
        if (acc && bus.s_sof) begin
          e_err = loading;
          loading = 1;
          word = 0;
          bq = {bus.s_data};
        end else if (acc && loading) begin
          bq.push_back(bus.s_data);
          if (bq.size() == BPW) begin
            e_write = 1;
            e_addr = AW'(word);
            for (int k = 0; k < BPW; k++) e_data[k*IW +: IW] = bq[k];
            bq.delete();
            word++;
            if (word == FW) begin
              loading = 0;
              tail = 2;
              e_ready = 0;
            end
          end
        end
      end
      e_busy = loading || tail == 2;
    end
  end
  task automatic send(input logic [IW-1:0] d, input logic sof);
    int guard = 0;
    bus.s_valid = 1'b1;
    bus.s_data = d;
    bus.s_sof = sof;
    forever begin
      @(negedge clk);
      if (bus.s_ready) break;
      if (++guard > 50) begin
        errors++;
        $display("FAIL accept_timeout: got s_ready=0 for 50 cycles expected acceptance at %0t", $time);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_sof = 1'b0;
  endtask
  task automatic run_beats(input int n, input bit rnd, input logic [IW-1:0] base, input int gap, input bit sof_first);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap) begin
        bus.s_valid = 1'b0;
        bus.s_sof = 1'($urandom);
        bus.s_data = $urandom;
        @(posedge clk);
        #1;
      end
      send(rnd ? IW'($urandom) : base + IW'(i), sof_first && i == 0);
    end
  endtask
  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask
  initial begin
    int w0, f0, e0;
    bus.s_valid = 1'b0;
    bus.s_sof = 1'b0;
    bus.s_data = '0;
    #1000000;
    $display("FAIL watchdog: got no finish expected completion at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int w0, f0, e0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_ready", WW'(bus.s_ready), '0);
    chk("reset_busy", WW'(bus.busy), '0);
    chk("reset_w_data", bus.w_data, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_release", WW'(bus.s_ready), WW'(1));
    w0 = n_wr; f0 = n_nf; e0 = n_fe;
    run_beats(BPW * FW, 0, 0, 0, 1);
    settle();
    chk("t1_writes", WW'(n_wr - w0), WW'(FW));
    chk("t1_new_frame", WW'(n_nf - f0), WW'(1));
    chk("t1_frame_error", WW'(n_fe - e0), '0);
    chk("t1_word0", wr_seq[w0], {32'd3, 32'd2, 32'd1, 32'd0});
    chk("t1_word767", wr_seq[w0 + FW - 1], {32'd3071, 32'd3070, 32'd3069, 32'd3068});
    chk("t1_addr767", WW'(wr_adr[w0 + FW - 1]), WW'(767));
    w0 = n_wr; f0 = n_nf;
    run_beats(BPW * FW, 1, 0, 50, 1);
    settle();
    chk("t2_writes", WW'(n_wr - w0), WW'(FW));
    chk("t2_new_frame", WW'(n_nf - f0), WW'(1));
    w0 = n_wr; f0 = n_nf;
    run_beats(5, 0, 32'hBAD0_0000, 0, 0);
    run_beats(BPW * FW, 0, 32'h100, 0, 1);
    settle();
    chk("t3_writes", WW'(n_wr - w0), WW'(FW));
    chk("t3_first_addr", WW'(wr_adr[w0]), '0);
    chk("t3_first_word", wr_seq[w0], {32'h103, 32'h102, 32'h101, 32'h100});
    w0 = n_wr; f0 = n_nf; e0 = n_fe;
    run_beats(402, 0, 0, 0, 1);
    run_beats(BPW * FW, 0, 32'h1000_0000, 0, 1);
    settle();
    chk("t4_frame_error", WW'(n_fe - e0), WW'(1));
    chk("t4_writes", WW'(n_wr - w0), WW'(100 + FW));
    chk("t4_new_frame", WW'(n_nf - f0), WW'(1));
    chk("t4_last_old_addr", WW'(wr_adr[w0 + 99]), WW'(99));
    chk("t4_restart_addr", WW'(wr_adr[w0 + 100]), '0);
    chk("t4_restart_word", wr_seq[w0 + 100], {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000});
    run_beats(BPW * 200, 1, 0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_s_ready", WW'(bus.s_ready), '0);
    chk("t5_async_write", WW'(bus.write), '0);
    chk("t5_async_busy", WW'(bus.busy), '0);
    chk("t5_async_w_addr", WW'(bus.w_addr_input), '0);
    chk("t5_async_w_data", bus.w_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    w0 = n_wr; f0 = n_nf;
    run_beats(BPW * FW, 1, 0, 10, 1);
    settle();
    chk("t5_writes", WW'(n_wr - w0), WW'(FW));
    chk("t5_new_frame", WW'(n_nf - f0), WW'(1));
    chk("t5_first_addr", WW'(wr_adr[w0]), '0);
    w0 = n_wr; f0 = n_nf;
    run_beats(BPW * FW, 0, 32'h2000_0000, 0, 1);
    run_beats(BPW * FW, 1, 0, 0, 1);
    settle();
    chk("t6_writes", WW'(n_wr - w0), WW'(2 * FW));
    chk("t6_new_frame", WW'(n_nf - f0), WW'(2));
    chk("t6_frame2_addr0", WW'(wr_adr[w0 + FW]), '0);
    chk("t6_frame2_last", WW'(wr_adr[w0 + 2 * FW - 1]), WW'(767));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
